// File: rtl/xcv5_dma_pingpong_buf.sv
// xcv5_dma_pingpong_buf: multi-channel ping-pong DMA staging buffer.
// Each channel owns two banks of 2**AW words. The producer fills the write
// bank and hands it over with a commit; the consumer drains the head bank and
// returns it with a release. All logic runs on the rising edge of gclk_i.clk.
//
// Optional feature: define DMABUF_PARITY_EN to store per-32-bit-lane even
// parity with each word and flag mismatches on read (par_err_o).
//
// Ports:
//   gclk_i        clock bundle (only .clk used)
//   rst_i         synchronous reset, active high
//   wr_ch_i       write channel select
//   wr_addr_i     word address in the channel's write bank
//   wr_data_i     write data
//   wr_par_i      even parity per 32-bit lane (parity build only)
//   wr_we_i       write strobe
//   wr_commit_i   hand the write bank of wr_ch_i to the reader
//   wr_len_i      valid word count of the committed bank
//   wr_ready_o    per channel: a bank is free for writing
//   rd_ch_i       read channel select
//   rd_addr_i     word address in the channel's head bank
//   rd_data_o     read data, one cycle latency
//   rd_len_o      committed length of the head bank of rd_ch_i
//   rd_valid_o    per channel: a committed bank is available
//   rd_release_i  return the head bank of rd_ch_i to the writer
//   ovf_err_o     sticky: write/commit with no free bank
//   udf_err_o     sticky: release with no committed bank
//   par_err_o     sticky: parity mismatch on read

package xcv5_dma_pingpong_buf_pkg;
  typedef struct packed {
    logic clk;
  } iu_clk_type;
endpackage

module xcv5_dma_pingpong_buf
  import xcv5_dma_pingpong_buf_pkg::*;
#(
  parameter  int NCH = 2,
  parameter  int DW  = 64,
  parameter  int AW  = 9,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int NL  = DW / 32
) (
  input  iu_clk_type        gclk_i,
  input  logic              rst_i,
  input  logic [CW-1:0]     wr_ch_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DW-1:0]     wr_data_i,
  input  logic [NL-1:0]     wr_par_i,
  input  logic              wr_we_i,
  input  logic              wr_commit_i,
  input  logic [AW:0]       wr_len_i,
  output logic [NCH-1:0]    wr_ready_o,
  input  logic [CW-1:0]     rd_ch_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DW-1:0]     rd_data_o,
  output logic [AW:0]       rd_len_o,
  output logic [NCH-1:0]    rd_valid_o,
  input  logic              rd_release_i,
  output logic              ovf_err_o,
  output logic              udf_err_o,
  output logic              par_err_o
);

`ifdef DMABUF_PARITY_EN
  localparam int RW = DW + NL;
`else
  localparam int RW = DW;
`endif
  localparam int DEPTH = NCH * 2 * (2 ** AW);

  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_HALF = 2'd1, ST_FULL = 2'd2} occ_e;

  logic clk;
  assign clk = gclk_i.clk;

  occ_e           st_q   [NCH];
  logic [NCH-1:0] wptr_q, rptr_q;
  logic [AW:0]    len_q  [NCH][2];
  logic           ovf_q, udf_q;
  logic [DW-1:0]  rd_data_q;
  logic [RW-1:0]  mem    [DEPTH];

  logic [NCH-1:0] cmt, rel, cmt_ok, rel_ok;
  logic           wr_sel_ok, wr_free, wbank, rbank;
  logic           mem_we, ovf_set, udf_set;
  logic [RW-1:0]  wr_word, rd_word;

  // Per-channel decode; out-of-range channel selects match nothing.
  always_comb begin
    cmt        = '0;
    rel        = '0;
    cmt_ok     = '0;
    rel_ok     = '0;
    wr_ready_o = '0;
    rd_valid_o = '0;
    wr_sel_ok  = 1'b0;
    wr_free    = 1'b0;
    wbank      = 1'b0;
    rbank      = 1'b0;
    rd_len_o   = '0;
    for (int c = 0; c < NCH; c++) begin
      wr_ready_o[c] = (st_q[c] != ST_FULL);
      rd_valid_o[c] = (st_q[c] != ST_EMPTY);
      cmt[c]        = wr_commit_i  && (wr_ch_i == c[CW-1:0]);
      rel[c]        = rd_release_i && (rd_ch_i == c[CW-1:0]);
      cmt_ok[c]     = cmt[c] && (st_q[c] != ST_FULL);
      rel_ok[c]     = rel[c] && (st_q[c] != ST_EMPTY);
      if (wr_ch_i == c[CW-1:0]) begin
        wr_sel_ok = 1'b1;
        wr_free   = (st_q[c] != ST_FULL);
        wbank     = wptr_q[c];
      end
      if (rd_ch_i == c[CW-1:0]) begin
        rbank    = rptr_q[c];
        rd_len_o = len_q[c][rptr_q[c]];
      end
    end
    mem_we  = wr_we_i && wr_sel_ok && wr_free;
    ovf_set = (|(cmt & ~cmt_ok)) || (wr_we_i && wr_sel_ok && !wr_free);
    udf_set = |(rel & ~rel_ok);
  end

  // Occupancy FSM per channel. A commit and a release together in HALF
  // cancel out on the state while both pointers still advance.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int c = 0; c < NCH; c++) begin
        st_q[c]     <= ST_EMPTY;
        len_q[c][0] <= '0;
        len_q[c][1] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (udf_set) udf_q <= 1'b1;
      for (int c = 0; c < NCH; c++) begin
        if (cmt_ok[c]) begin
          len_q[c][wptr_q[c]] <= wr_len_i;
          wptr_q[c]           <= ~wptr_q[c];
        end
        if (rel_ok[c]) rptr_q[c] <= ~rptr_q[c];
        if (cmt_ok[c] && !rel_ok[c])
          st_q[c] <= (st_q[c] == ST_EMPTY) ? ST_HALF : ST_FULL;
        else if (rel_ok[c] && !cmt_ok[c])
          st_q[c] <= (st_q[c] == ST_FULL) ? ST_HALF : ST_EMPTY;
      end
    end
  end

`ifdef DMABUF_PARITY_EN
  assign wr_word = {wr_par_i, wr_data_i};
`else
  assign wr_word = wr_data_i;
`endif

  // Storage is never reset; a write in the same cycle as a read of the same
  // address returns the old word.
  always_ff @(posedge clk) begin
    if (mem_we) mem[{wr_ch_i, wbank, wr_addr_i}] <= wr_word;
  end

  assign rd_word = mem[{rd_ch_i, rbank, rd_addr_i}];

  always_ff @(posedge clk) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= rd_word[DW-1:0];
  end

`ifdef DMABUF_PARITY_EN
  logic par_bad, par_q;

  always_comb begin
    par_bad = 1'b0;
    for (int l = 0; l < NL; l++)
      par_bad = par_bad | ((^rd_word[l*32 +: 32]) != rd_word[DW+l]);
  end

  // Registered alongside rd_data so the flag rises with the offending word.
  always_ff @(posedge clk) begin
    if (rst_i)        par_q <= 1'b0;
    else if (par_bad) par_q <= 1'b1;
  end

  assign par_err_o = par_q;
`else
  logic unused_par;
  assign unused_par = ^wr_par_i;
  assign par_err_o  = 1'b0;
`endif

  assign rd_data_o = rd_data_q;
  assign ovf_err_o = ovf_q;
  assign udf_err_o = udf_q;

endmodule
